// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - chip-enable / strobe bus-cycle sequencer with per-target wait states
module mem_access_seq #(
    parameter int DW      = 32,
    parameter int WS_MEM0 = 2,
    parameter int WS_MEM1 = 3,
    parameter int WS_CS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [DW-1:0] req_wdata,
    input  logic          memce0,
    input  logic          memce1,
    input  logic          cs,
    input  logic [DW-1:0] bus_rdata,
    output logic          ce0_n,
    output logic          ce1_n,
    output logic          cs_n,
    output logic          oe_n,
    output logic          we_n,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_wdata_oe,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    // Wait states are 4-bit; zero (given or after truncation) would leave
    // STROBE with no cycle to exit from, so it is promoted to one.
    localparam logic [3:0] WS0_T = WS_MEM0[3:0];
    localparam logic [3:0] WS1_T = WS_MEM1[3:0];
    localparam logic [3:0] WSC_T = WS_CS[3:0];
    localparam logic [3:0] WS0_C = (WS0_T == 4'd0) ? 4'd1 : WS0_T;
    localparam logic [3:0] WS1_C = (WS1_T == 4'd0) ? 4'd1 : WS1_T;
    localparam logic [3:0] WSC_C = (WSC_T == 4'd0) ? 4'd1 : WSC_T;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [2:0]      r_sel;
    logic [3:0]      r_cnt;
    logic [DW-1:0]   r_rdata;

    logic [2:0]      w_sel_in;
    logic            w_sel_ok;
    logic [3:0]      w_ws_load;
    logic            w_accept;
    logic            w_last_strobe;
    logic            w_ce_act;

    assign w_sel_in      = {cs, memce1, memce0};
    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign w_last_strobe = (r_state == S_STROBE) && (r_cnt <= 4'd1);

    // Decode the one-hot select into a target wait count; anything else is a decode error
    always_comb begin
        w_sel_ok  = 1'b0;
        w_ws_load = 4'd0;
        case (w_sel_in)
            3'b001: begin
                w_sel_ok  = 1'b1;
                w_ws_load = WS0_C;
            end
            3'b010: begin
                w_sel_ok  = 1'b1;
                w_ws_load = WS1_C;
            end
            3'b100: begin
                w_sel_ok  = 1'b1;
                w_ws_load = WSC_C;
            end
            default: begin
                w_sel_ok  = 1'b0;
                w_ws_load = 4'd0;
            end
        endcase
    end

    // State register; async reset drops every strobe the moment rst_n falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing through setup, strobe wait states and hold
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_sel_ok ? S_SETUP : S_ERR;
                end
            end
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: begin
                if (w_last_strobe) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request capture at accept, wait-state countdown and read-data sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_sel   <= 3'b000;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_sel   <= w_sel_ok ? w_sel_in : 3'b000;
                r_cnt   <= w_ws_load;
            end else if (r_state == S_STROBE) begin
                r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
                if (w_last_strobe && !r_we) begin
                    r_rdata <= bus_rdata;
                end
            end
        end
    end

    // Bus strobes and response are decoded from state so reset clears them without a clock
    always_comb begin
        w_ce_act     = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
        req_ready    = (r_state == S_IDLE);
        ce0_n        = !(w_ce_act && r_sel[0]);
        ce1_n        = !(w_ce_act && r_sel[1]);
        cs_n         = !(w_ce_act && r_sel[2]);
        oe_n         = !((r_state == S_STROBE) && !r_we);
        we_n         = !((r_state == S_STROBE) && r_we);
        bus_wdata_oe = w_ce_act && r_we;
        bus_wdata    = bus_wdata_oe ? r_wdata : '0;
        rsp_valid    = (r_state == S_HOLD) || (r_state == S_ERR);
        rsp_err      = (r_state == S_ERR);
        rsp_rdata    = (r_state == S_ERR) ? '0 : r_rdata;
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed scoreboard bench for mem_access_seq
module tb_mem_access_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          memce0 = 1'b0;
    logic          memce1 = 1'b0;
    logic          cs = 1'b0;
    logic [DW-1:0] bus_rdata;
    logic          ce0_n, ce1_n, cs_n, oe_n, we_n;
    logic [DW-1:0] bus_wdata;
    logic          bus_wdata_oe;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic [DW-1:0] rd_drive = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic [DW-1:0] model_rd = '0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rsp = 0;
    int lo_ce0 = 0, lo_ce1 = 0, lo_cs = 0, lo_oe = 0, lo_we = 0, lo_woe = 0;
    int bad_wd = 0;
    int inv_bad = 0;

    // Bus answers with the planted word only while the sequencer is enabling output
    assign bus_rdata = (!oe_n) ? rd_drive : 32'h0BAD_F00D;

    mem_access_seq #(.DW(DW), .WS_MEM0(2), .WS_MEM1(3), .WS_CS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wdata(req_wdata),
        .memce0(memce0), .memce1(memce1), .cs(cs),
        .bus_rdata(bus_rdata),
        .ce0_n(ce0_n), .ce1_n(ce1_n), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n),
        .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200000 required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_cnt();
        lo_ce0 = 0; lo_ce1 = 0; lo_cs = 0; lo_oe = 0; lo_we = 0; lo_woe = 0; bad_wd = 0;
    endtask

    // Monitor: strobe activity counters, invariants and response scoreboard
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!ce0_n) lo_ce0 = lo_ce0 + 1;
        if (!ce1_n) lo_ce1 = lo_ce1 + 1;
        if (!cs_n)  lo_cs  = lo_cs + 1;
        if (!oe_n)  lo_oe  = lo_oe + 1;
        if (!we_n)  lo_we  = lo_we + 1;
        if (bus_wdata_oe) begin
            lo_woe = lo_woe + 1;
            if (bus_wdata !== cur_wdata) bad_wd = bad_wd + 1;
        end
        if ((!oe_n && !we_n) || ($countones({~ce0_n, ~ce1_n, ~cs_n}) > 1))
            inv_bad = inv_bad + 1;
        if (rsp_valid === 1'b1) begin
            n_rsp = n_rsp + 1;
            chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] wdata, input logic [2:0] sel,
                          input int ws, input logic [31:0] rd, input bit push, output int t);
        int k;
        bit err;
        @(negedge clk);
        req_we = we;
        req_wdata = wdata;
        {cs, memce1, memce0} = sel;
        rd_drive = rd;
        cur_wdata = wdata;
        req_valid = 1'b1;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", 32'(k < 50), 32'd1);
        t = cyc;
        err = !(sel == 3'b001 || sel == 3'b010 || sel == 3'b100);
        if (push) begin
            if (err) begin
                sb.push_back('{rdata: 32'h0, err: 1'b1, cyc: t + 1});
            end else begin
                if (!we) model_rd = rd;
                sb.push_back('{rdata: model_rd, err: 1'b0, cyc: t + 2 + ws});
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        clear_cnt();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(k < 100), 32'd1);
    endtask

    initial begin
        int t;
        int k;
        int ta[3];
        int rsp0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ce0_n", 32'(ce0_n), 32'd1);
        chk("rst_ce1_n", 32'(ce1_n), 32'd1);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_wdata_oe", 32'(bus_wdata_oe), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Read from memory 0
        do_req(1'b0, 32'h0, 3'b001, 2, 32'hDEADBEEF, 1'b1, t);
        wait_idle();
        chk("rd0_ce0_low", lo_ce0, 4);
        chk("rd0_oe_low", lo_oe, 2);
        chk("rd0_we_low", lo_we, 0);
        chk("rd0_other_ce", lo_ce1 + lo_cs, 0);

        // Write to memory 1
        do_req(1'b1, 32'h12345678, 3'b010, 3, 32'h0, 1'b1, t);
        wait_idle();
        chk("wr1_ce1_low", lo_ce1, 5);
        chk("wr1_we_low", lo_we, 3);
        chk("wr1_oe_low", lo_oe, 0);
        chk("wr1_wdata_oe", lo_woe, 5);
        chk("wr1_wdata_bad", bad_wd, 0);

        // Decode errors: no select, then two selects
        do_req(1'b0, 32'h0, 3'b000, 0, 32'h0, 1'b1, t);
        @(negedge clk);
        chk("err0_ready_t1", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("err0_ready_t2", 32'(req_ready), 32'd1);
        chk("err0_activity", lo_ce0 + lo_ce1 + lo_cs + lo_oe + lo_we + lo_woe, 0);
        do_req(1'b0, 32'h0, 3'b011, 0, 32'h0, 1'b1, t);
        @(negedge clk);
        chk("err3_ready_t1", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("err3_ready_t2", 32'(req_ready), 32'd1);
        chk("err3_activity", lo_ce0 + lo_ce1 + lo_cs + lo_oe + lo_we + lo_woe, 0);

        // Back-to-back peripheral reads with req_valid held high
        @(posedge clk);
        #1;
        clear_cnt();
        rsp0 = n_rsp;
        @(negedge clk);
        req_we = 1'b0;
        {cs, memce1, memce0} = 3'b100;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (req_ready !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_accept_timeout", 32'(k < 20), 32'd1);
            ta[i] = cyc;
            rd_drive = 32'h1111_0000 + 32'(i);
            model_rd = rd_drive;
            sb.push_back('{rdata: model_rd, err: 1'b0, cyc: ta[i] + 3});
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();
        chk("b2b_gap01", ta[1] - ta[0], 4);
        chk("b2b_gap12", ta[2] - ta[1], 4);
        chk("b2b_cs_low", lo_cs, 9);
        chk("b2b_oe_low", lo_oe, 3);
        chk("b2b_rsp_count", n_rsp - rsp0, 3);

        // Reset pulse during the second strobe cycle of a memory-1 write
        do_req(1'b1, 32'hCAFEF00D, 3'b010, 3, 32'h0, 1'b0, t);
        repeat (3) @(negedge clk);
        chk("abort_we_before", 32'(we_n), 32'd0);
        chk("abort_ce1_before", 32'(ce1_n), 32'd0);
        rsp0 = n_rsp;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", 32'(we_n), 32'd1);
        chk("abort_ce1_n", 32'(ce1_n), 32'd1);
        chk("abort_wdata_oe", 32'(bus_wdata_oe), 32'd0);
        model_rd = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_rsp", n_rsp - rsp0, 0);
        do_req(1'b0, 32'h0, 3'b001, 2, 32'h0F0F1234, 1'b1, t);
        wait_idle();
        chk("post_rst_ce0_low", lo_ce0, 4);

        // Selects toggling after accept of a memory-0 read
        do_req(1'b0, 32'h0, 3'b001, 2, 32'h55AA33CC, 1'b1, t);
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            memce0 = ~memce0;
            memce1 = ~memce1;
            k++;
        end
        {cs, memce1, memce0} = 3'b000;
        chk("tog_ce0_low", lo_ce0, 4);
        chk("tog_ce1_low", lo_ce1, 0);
        chk("tog_oe_low", lo_oe, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("invariants", inv_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
Bus-cycle sequencer that sits directly downstream of the address/chip-select decoder. It accepts one request at a time, together with the decoder's one-hot selects (memce0, memce1, cs). It then drives an active-low chip-enable, output-enable and write-enable sequence with per-target wait states onto a shared 32-bit external data bus. Read data and completion status are returned to the requester through a single-cycle response pulse.

Parameters:
DW, 32, data bus width
WS_MEM0, 2, strobe cycles for memce0 target (legal range 1..15)
WS_MEM1, 3, strobe cycles for memce1 target (legal range 1..15)
WS_CS, 1, strobe cycles for cs target (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = write, 0 = read
req_wdata  in  DW  write data
memce0  in  1  decoder select, memory 0
memce1  in  1  decoder select, memory 1
cs  in  1  decoder select, peripheral
bus_rdata  in  DW  external read data
ce0_n  out  1  memory 0 chip enable, active low
ce1_n  out  1  memory 1 chip enable, active low
cs_n  out  1  peripheral chip select, active low
oe_n  out  1  output enable, active low
we_n  out  1  write enable, active low
bus_wdata  out  DW  external write data
bus_wdata_oe  out  1  write-data driver enable
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DW  captured read data, valid with rsp_valid
rsp_err  out  1  decode error flag, valid with rsp_valid

Behaviour:
- Reset (async assert, sync release): state IDLE; ce0_n=ce1_n=cs_n=oe_n=we_n=1; bus_wdata=0; bus_wdata_oe=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0.
- Reset asserted mid-cycle forces all strobes high immediately (asynchronously) and aborts the cycle. No rsp_valid is issued for an aborted cycle.
- req_ready=1 only in IDLE (combinational from state). Accept happens at the rising edge where req_valid & req_ready.
- At accept, register req_we, req_wdata and the selects. The wait count is loaded from the parameter of the selected target.
- Select check at accept:
  - exactly one select high -> SETUP.
  - zero or more than one select high -> ERR.
- States:
  - IDLE: all strobes inactive.
  - SETUP, 1 cycle: selected CE low. For a write, bus_wdata driven and bus_wdata_oe=1. oe_n/we_n high.
  - STROBE, WS cycles: CE low. oe_n low for a read; we_n low for a write. Counter decrements each cycle and exits on its last cycle.
  - HOLD, 1 cycle: CE low, oe_n/we_n high. bus_wdata_oe stays 1 for a write. rsp_valid=1, rsp_err=0.
  - ERR, 1 cycle: no strobe or CE asserted. rsp_valid=1, rsp_err=1, rsp_rdata=0.
- After HOLD or ERR, return to IDLE.
- Read data: bus_rdata is sampled at the rising edge that ends the last STROBE cycle and held on rsp_rdata until the next read completes. For writes, rsp_rdata holds its previous value.
- Latency, from accept edge at cycle T:
  - SETUP at T+1; STROBE at T+2..T+1+WS; HOLD/rsp_valid at T+2+WS; IDLE/ready at T+3+WS.
  - ERR (rsp_valid) at T+1; IDLE at T+2.
- Timing invariants:
  - Back-to-back throughput is one access per WS+3 cycles.
  - oe_n and we_n are never low together.
  - No two CEs are ever low together.
  - CE is never low outside SETUP/STROBE/HOLD.
- Input stability: changes to the selects or req_wdata after accept have no effect on the cycle in progress.
- Wait-state parameter clamping: a parameter of 0 is treated as 1; values above 15 are truncated to 4 bits, and a truncated value of 0 is also treated as 1.

Test Plan:
- Read memce0=1 (WS_MEM0=2), bus_rdata=32'hDEADBEEF during strobe -> ce0_n low 4 cycles, oe_n low 2 cycles; rsp_valid at T+4 with rsp_rdata=32'hDEADBEEF, rsp_err=0.
- Write memce1=1, req_wdata=32'h12345678 -> ce1_n low 5 cycles, we_n low 3 cycles, bus_wdata_oe high 5 cycles, bus_wdata=32'h12345678; rsp_valid at T+5.
- Read with all selects 0, then with memce0=memce1=1 -> no CE/strobe activity; rsp_valid=1 and rsp_err=1 at T+1; req_ready back high at T+2.
- Back-to-back cs reads with req_valid held high -> accepts spaced exactly 4 cycles apart; cs_n low 3 cycles each; rsp_valid once per access.
- rst_n pulsed low during the second STROBE cycle of a memce1 write -> we_n and ce1_n go high immediately; no rsp_valid; after release, req_ready=1 and the next request completes normally.
- Toggle memce0/memce1 after accept of a memce0 read -> only ce0_n toggles; latency unchanged.
